// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 data cache with miss sequencer.
// Define DCACHE_STATS_EN to add the hit_count_o/miss_count_o statistics ports.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | serving hits; a miss launches writeback or refill
// S_WRITEBACK | dirty victim line being written to memory
// S_ALLOCATE  | refill read outstanding; line captured on ack
// S_REFILL  | one settle cycle before the held request replays as a hit
module dcache_controller #(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_count_o,
  output logic [31:0]          miss_count_o
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - 5 - IW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_REFILL
  } state_t;

  state_t state;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TW-1:0]        tag_arr  [LINES];
  logic [LINE_BITS-1:0] data_arr [LINES];

  logic [IW-1:0] idx;
  logic [TW-1:0] addr_tag;
  logic [2:0]    word_sel;
  logic [7:0]    word_lsb;
  logic          req;
  logic          hit;
  logic          victim_dirty;
  logic          write_hit;
  logic          unused_addr_bits;

  assign idx          = cpu_addr_i[4+IW:5];
  assign addr_tag     = cpu_addr_i[31:5+IW];
  assign word_sel     = cpu_addr_i[4:2];
  assign word_lsb     = {word_sel, 5'b0};
  assign req          = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit          = valid_q[idx] & (tag_arr[idx] == addr_tag);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];
  assign write_hit    = (state == S_IDLE) & cpu_MemWrite_i & hit;
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign cpu_stall_o = (state != S_IDLE) | (req & ~hit);
  assign cpu_data_o  = data_arr[idx][word_lsb +: 32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && !hit) begin
            mem_enable_o <= 1'b1;
            if (victim_dirty) begin
              state       <= S_WRITEBACK;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {tag_arr[idx], idx, 5'b0};
              mem_data_o  <= data_arr[idx];
            end else begin
              state       <= S_ALLOCATE;
              mem_write_o <= 1'b0;
              mem_addr_o  <= {addr_tag, idx, 5'b0};
            end
          end
        end
        S_WRITEBACK: begin
          // Enable stays high: the refill request follows straight on.
          if (mem_ack_i) begin
            state       <= S_ALLOCATE;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {addr_tag, idx, 5'b0};
          end
        end
        S_ALLOCATE: begin
          if (mem_ack_i) begin
            state        <= S_REFILL;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
          end
        end
        S_REFILL: begin
          state <= S_IDLE;
        end
        default: begin
          state        <= S_IDLE;
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == S_ALLOCATE && mem_ack_i) begin
        data_arr[idx] <= mem_data_i;
        tag_arr[idx]  <= addr_tag;
      end else if (write_hit) begin
        data_arr[idx][word_lsb +: 32] <= cpu_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state == S_ALLOCATE && mem_ack_i) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

`ifdef DCACHE_STATS_EN
  // The replayed hit right after REFILL belongs to a miss, not a new hit.
  logic refill_done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      refill_done_q <= 1'b0;
      hit_count_o   <= '0;
      miss_count_o  <= '0;
    end else begin
      refill_done_q <= (state == S_REFILL);
      if (state == S_IDLE && req && hit && !refill_done_q)
        hit_count_o <= hit_count_o + 32'd1;
      if (state == S_IDLE && req && !hit)
        miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif

endmodule
